spmm_mem_arbiter: RTL and testbench

- Shares the accelerator's single memory read port among N_REQ address schedulers (Y data, X data, X metadata, ...).
- Each scheduler emits 48-bit block requests {len[15:0] elements, byte_addr[31:0]}.
- The block arbitrates round-robin, locks the grant for the whole request, and splits it into bus-word beats.
- It tags each issued beat so in-order read responses are routed back to the originating scheduler with a last-beat flag.

---
 rtl/spmm_mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_spmm_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmm_mem_arbiter.sv
// Round-robin arbiter sharing one memory read port among N_REQ block schedulers.
// Splits each block request into bus-word beats and routes in-order responses back by tag.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | pick next valid requester from rr_ptr, latch its request
// ISSUE  | issue beats of the latched request until the last handshake
module spmm_mem_arbiter #(
  parameter int N_REQ           = 3,
  parameter int DATA_SIZE       = 32,
  parameter int BUS_WIDTH       = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*48-1:0]    req_data_i,
  output logic                   mem_req_o,
  output logic [31:0]            mem_add_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_r_valid_i,
  input  logic [BUS_WIDTH-1:0]   mem_r_data_i,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic [BUS_WIDTH-1:0]   rsp_data_o,
  output logic                   rsp_last_o,
  output logic                   busy_o
);

  localparam int BUS_BYTES  = BUS_WIDTH / 8;
  localparam int ELEM_BYTES = DATA_SIZE / 8;
  localparam int OFF_W      = $clog2(BUS_BYTES);
  localparam int OWN_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] ADDR_MASK = 32'(BUS_BYTES - 1);

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e             state_q, state_d;
  logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [31:0]        beat_q, beat_d;
  logic [31:0]        beats_q, beats_d;
  logic [31:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OWN_W-1:0]   tag_owner_q [MAX_OUTSTANDING];
  logic [OWN_W-1:0]   tag_owner_d [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] tag_last_q, tag_last_d;

  logic [47:0]        req_arr [N_REQ];
  logic               sel_found;
  logic [OWN_W-1:0]   sel_idx;
  int                 idx;
  logic [47:0]        sel_data;
  logic [15:0]        sel_len;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_beats;
  logic               can_issue, grant, push, pop, last_beat;

  function automatic logic [OWN_W-1:0] rr_next(input logic [OWN_W-1:0] o);
    return (o == OWN_W'(N_REQ - 1)) ? '0 : o + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) req_arr[i] = req_data_i[i*48 +: 48];
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!sel_found && req_valid_i[OWN_W'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = OWN_W'(idx);
      end
    end
  end

  assign sel_data  = req_arr[sel_idx];
  assign sel_len   = sel_data[47:32];
  assign sel_addr  = sel_data[31:0] & ~ADDR_MASK;
  // Byte count fits easily in 32 bits; round up to whole bus words.
  assign sel_beats = (32'(sel_len) * 32'(ELEM_BYTES) + ADDR_MASK) >> OFF_W;

  assign can_issue = (state_q == S_ISSUE) && (cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign grant     = can_issue && mem_gnt_i;
  assign pop       = mem_r_valid_i && (cnt_q != '0);
  assign last_beat = (beat_q == beats_q - 32'd1);
  assign push      = grant;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    beat_d      = beat_q;
    beats_d     = beats_q;
    addr_d      = addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tag_owner_d = tag_owner_q;
    tag_last_d  = tag_last_q;
    cnt_d       = cnt_q;
    req_ready_o = '0;

    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          owner_d = sel_idx;
          if (sel_len == 16'd0) begin
            req_ready_o[sel_idx] = 1'b1;
            rr_ptr_d             = rr_next(sel_idx);
          end else begin
            beats_d = sel_beats;
            beat_d  = '0;
            addr_d  = sel_addr;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (grant) begin
          beat_d = beat_q + 32'd1;
          addr_d = addr_q + 32'(BUS_BYTES);
          if (last_beat) begin
            req_ready_o[owner_q] = 1'b1;
            rr_ptr_d             = rr_next(owner_q);
            state_d              = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      tag_owner_d[wr_ptr_q] = owner_q;
      tag_last_d[wr_ptr_q]  = last_beat;
      wr_ptr_d              = ptr_next(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_next(rd_ptr_q);

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_q     <= '0;
      beats_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_last_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_owner_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      beat_q      <= beat_d;
      beats_q     <= beats_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_last_q  <= tag_last_d;
      tag_owner_q <= tag_owner_d;
    end
  end

  assign mem_req_o  = can_issue;
  assign mem_add_o  = addr_q;
  assign busy_o     = (state_q == S_ISSUE) || (cnt_q != '0);

  // A response with no tag in flight is dropped rather than misrouted.
  always_comb begin
    rsp_valid_o = '0;
    if (pop) rsp_valid_o[tag_owner_q[rd_ptr_q]] = 1'b1;
  end
  assign rsp_data_o = pop ? mem_r_data_i : '0;
  assign rsp_last_o = pop && tag_last_q[rd_ptr_q];

endmodule

// File: tb/tb_spmm_mem_arbiter.sv
// Directed bench for spmm_mem_arbiter: one task per scenario with hand-computed expectations.
module tb_spmm_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_ni, clear_i;
  logic [2:0]   req_valid, req_ready;
  logic [47:0]  rd0, rd1, rd2;
  logic [143:0] req_data;
  logic         mem_req, mem_gnt, mem_r_valid;
  logic [31:0]  mem_add;
  logic [127:0] mem_r_data, rsp_data;
  logic [2:0]   rsp_valid;
  logic         rsp_last, busy;

  int checks = 0;
  int errors = 0;

  assign req_data = {rd2, rd1, rd0};

  always #5 clk = ~clk;

  spmm_mem_arbiter #(.N_REQ(3), .DATA_SIZE(32), .BUS_WIDTH(128), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .mem_req_o(mem_req), .mem_add_o(mem_add), .mem_gnt_i(mem_gnt),
    .mem_r_valid_i(mem_r_valid), .mem_r_data_i(mem_r_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_last_o(rsp_last), .busy_o(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0; clear_i = 1'b0; req_valid = '0; rd0 = '0; rd1 = '0; rd2 = '0;
    mem_gnt = 1'b0; mem_r_valid = 1'b0; mem_r_data = '0;
    step(); step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    settle();
    checks++;
    if ({req_ready, mem_req, mem_add, rsp_valid, rsp_last, busy} !== 41'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {req_ready, mem_req, mem_add, rsp_valid, rsp_last, busy});
    end
    checks++;
    if (rsp_data !== 128'd0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 3'b010; rd1 = {16'd8, 32'h1000}; mem_gnt = 1'b1;
    settle();
    checks++;
    if ({mem_req, req_ready} !== 4'b0000) begin errors++; $display("FAIL single_latch got %b exp 0000", {mem_req, req_ready}); end
    step(); settle();
    checks++;
    if ({mem_req, mem_add, req_ready} !== {1'b1, 32'h1000, 3'b000}) begin
      errors++; $display("FAIL single_beat0 got %h exp %h", {mem_req, mem_add, req_ready}, {1'b1, 32'h1000, 3'b000});
    end
    step();
    mem_r_valid = 1'b1; mem_r_data = {4{32'hA5A5_0001}};
    settle();
    checks++;
    if ({mem_req, mem_add, req_ready, rsp_valid, rsp_last} !== {1'b1, 32'h1010, 3'b010, 3'b010, 1'b0}) begin
      errors++; $display("FAIL single_beat1 got %h exp %h", {mem_req, mem_add, req_ready, rsp_valid, rsp_last}, {1'b1, 32'h1010, 3'b010, 3'b010, 1'b0});
    end
    checks++;
    if (rsp_data !== {4{32'hA5A5_0001}}) begin errors++; $display("FAIL single_rsp_data got %h exp %h", rsp_data, {4{32'hA5A5_0001}}); end
    req_valid = '0;
    step();
    mem_r_data = {4{32'h5A5A_0002}};
    settle();
    checks++;
    if ({mem_req, rsp_valid, rsp_last, busy, rsp_data} !== {1'b0, 3'b010, 1'b1, 1'b1, {4{32'h5A5A_0002}}}) begin
      errors++; $display("FAIL single_last_rsp got %h exp %h", {mem_req, rsp_valid, rsp_last, busy, rsp_data}, {1'b0, 3'b010, 1'b1, 1'b1, {4{32'h5A5A_0002}}});
    end
    step();
    mem_r_valid = 1'b0;
    settle();
    checks++;
    if ({busy, rsp_valid} !== 4'b0000) begin errors++; $display("FAIL single_idle got %b exp 0000", {busy, rsp_valid}); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_own  [4];
    logic [31:0] exp_addr [4];
    exp_own  = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_addr = '{32'h0, 32'h100, 32'h200, 32'h0};
    apply_reset();
    req_valid = 3'b111; mem_gnt = 1'b1;
    rd0 = {16'd4, 32'h0}; rd1 = {16'd4, 32'h100}; rd2 = {16'd4, 32'h200};
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++;
      if ({mem_req, req_ready} !== 4'b0000) begin errors++; $display("FAIL rr_idle%0d got %b exp 0000", k, {mem_req, req_ready}); end
      step(); settle();
      checks++;
      if ({mem_req, mem_add, req_ready} !== {1'b1, exp_addr[k], exp_own[k]}) begin
        errors++; $display("FAIL rr_grant%0d got %h exp %h", k, {mem_req, mem_add, req_ready}, {1'b1, exp_addr[k], exp_own[k]});
      end
      if (k == 3) req_valid = '0;
      step();
    end
    mem_r_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++;
      if ({rsp_valid, rsp_last} !== {exp_own[k], 1'b1}) begin
        errors++; $display("FAIL rr_rsp%0d got %b exp %b", k, {rsp_valid, rsp_last}, {exp_own[k], 1'b1});
      end
      step();
    end
    mem_r_valid = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy got %b exp 0", busy); end
  endtask

  task automatic test_stall();
    apply_reset();
    req_valid = 3'b001; rd0 = {16'd12, 32'h40}; mem_gnt = 1'b1;
    step(); settle();
    checks++;
    if ({mem_req, mem_add} !== {1'b1, 32'h40}) begin errors++; $display("FAIL stall_beat0 got %h exp %h", {mem_req, mem_add}, {1'b1, 32'h40}); end
    step();
    mem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if ({mem_req, mem_add, req_ready} !== {1'b1, 32'h50, 3'b000}) begin
        errors++; $display("FAIL stall_hold%0d got %h exp %h", i, {mem_req, mem_add, req_ready}, {1'b1, 32'h50, 3'b000});
      end
      step();
    end
    mem_gnt = 1'b1;
    settle();
    checks++;
    if ({mem_req, mem_add, req_ready} !== {1'b1, 32'h50, 3'b000}) begin
      errors++; $display("FAIL stall_beat1 got %h exp %h", {mem_req, mem_add, req_ready}, {1'b1, 32'h50, 3'b000});
    end
    step(); settle();
    checks++;
    if ({mem_req, mem_add, req_ready} !== {1'b1, 32'h60, 3'b001}) begin
      errors++; $display("FAIL stall_beat2 got %h exp %h", {mem_req, mem_add, req_ready}, {1'b1, 32'h60, 3'b001});
    end
    req_valid = '0;
    step();
    mem_r_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      settle();
      checks++;
      if ({mem_req, rsp_valid, rsp_last} !== {1'b0, 3'b001, (j == 2)}) begin
        errors++; $display("FAIL stall_rsp%0d got %b exp %b", j, {mem_req, rsp_valid, rsp_last}, {1'b0, 3'b001, (j == 2)});
      end
      step();
    end
    mem_r_valid = 1'b0;
  endtask

  task automatic test_outstanding();
    apply_reset();
    req_valid = 3'b001; rd0 = {16'd32, 32'h2000}; mem_gnt = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++;
      if ({mem_req, mem_add} !== {1'b1, 32'h2000 + 32'(16 * k)}) begin
        errors++; $display("FAIL out_beat%0d got %h exp %h", k, {mem_req, mem_add}, {1'b1, 32'h2000 + 32'(16 * k)});
      end
      step();
    end
    settle();
    checks++;
    if ({mem_req, busy} !== 2'b01) begin errors++; $display("FAIL out_full got %b exp 01", {mem_req, busy}); end
    step();
    for (int k = 4; k < 8; k++) begin
      mem_r_valid = 1'b1;
      settle();
      checks++;
      if ({mem_req, rsp_valid, rsp_last} !== {1'b0, 3'b001, 1'b0}) begin
        errors++; $display("FAIL out_pop_full%0d got %b exp 00010", k, {mem_req, rsp_valid, rsp_last});
      end
      step();
      mem_r_valid = 1'b0;
      settle();
      checks++;
      if ({mem_req, mem_add, req_ready} !== {1'b1, 32'h2000 + 32'(16 * k), (k == 7) ? 3'b001 : 3'b000}) begin
        errors++; $display("FAIL out_resume%0d got %h exp %h", k, {mem_req, mem_add, req_ready}, {1'b1, 32'h2000 + 32'(16 * k), (k == 7) ? 3'b001 : 3'b000});
      end
      if (k == 7) req_valid = '0;
      step();
    end
    mem_r_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      settle();
      checks++;
      if ({mem_req, rsp_valid, rsp_last, busy} !== {1'b0, 3'b001, (j == 3), 1'b1}) begin
        errors++; $display("FAIL out_drain%0d got %b exp %b", j, {mem_req, rsp_valid, rsp_last, busy}, {1'b0, 3'b001, (j == 3), 1'b1});
      end
      step();
    end
    mem_r_valid = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL out_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_zero_len();
    apply_reset();
    req_valid = 3'b010; rd1 = {16'd4, 32'h100}; mem_gnt = 1'b1;
    step(); settle();
    checks++;
    if ({mem_add, req_ready} !== {32'h100, 3'b010}) begin errors++; $display("FAIL zl_setup got %h exp %h", {mem_add, req_ready}, {32'h100, 3'b010}); end
    req_valid = '0;
    step();
    mem_r_valid = 1'b1;
    step();
    mem_r_valid = 1'b0;
    req_valid = 3'b100; rd2 = {16'd0, 32'h0};
    settle();
    checks++;
    if ({req_ready, mem_req} !== 4'b1000) begin errors++; $display("FAIL zl_pulse got %b exp 1000", {req_ready, mem_req}); end
    step();
    req_valid = 3'b110; rd1 = {16'd4, 32'h400}; rd2 = {16'd4, 32'h500};
    settle();
    checks++;
    if ({req_ready, mem_req} !== 4'b0000) begin errors++; $display("FAIL zl_no_issue got %b exp 0000", {req_ready, mem_req}); end
    step(); settle();
    checks++;
    if ({mem_req, mem_add, req_ready} !== {1'b1, 32'h400, 3'b010}) begin
      errors++; $display("FAIL zl_rr_ptr got %h exp %h", {mem_req, mem_add, req_ready}, {1'b1, 32'h400, 3'b010});
    end
    req_valid = '0;
    step();
    mem_r_valid = 1'b1;
    step();
    mem_r_valid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req_valid = 3'b001; rd0 = {16'd16, 32'h800}; mem_gnt = 1'b1;
    step(); step(); step();
    rst_ni = 1'b0; mem_gnt = 1'b0; req_valid = '0;
    step();
    rst_ni = 1'b1;
    settle();
    checks++;
    if ({req_ready, mem_req, mem_add, rsp_valid, rsp_last, busy} !== 41'd0) begin
      errors++; $display("FAIL mid_reset_outputs got %h exp 0", {req_ready, mem_req, mem_add, rsp_valid, rsp_last, busy});
    end
    mem_r_valid = 1'b1; mem_r_data = {4{32'hDEAD_BEEF}};
    settle();
    checks++;
    if ({rsp_valid, rsp_last, rsp_data} !== 132'd0) begin
      errors++; $display("FAIL mid_reset_late_rsp got %h exp 0", {rsp_valid, rsp_last, rsp_data});
    end
    step();
    mem_r_valid = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b exp 0", busy); end
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; req_valid = '0; rd0 = '0; rd1 = '0; rd2 = '0;
    mem_gnt = 1'b0; mem_r_valid = 1'b0; mem_r_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_outstanding();
    test_zero_len();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
